// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-channel select link (transmit mux and the
// downstream demultiplexer).
//   NCH              number of channels
//   sel_t            the {s1,s0} select code carried alongside each word
//   SEL_CH1..SEL_CH4 select codes for channels 1..4
//   state_t          output-register occupancy state of the transmit mux
package mux4_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH1 = 2'd0;
  localparam sel_t SEL_CH2 = 2'd1;
  localparam sel_t SEL_CH3 = 2'd2;
  localparam sel_t SEL_CH4 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb4.sv
// Purely combinational 4-way round-robin arbiter.
// The search starts one past the last granted channel (ptr+1, ptr+2, ptr+3, ptr).
// Ports:
//   req      in   requesting channels, bit i = channel i+1
//   ptr      in   last granted channel index
//   en       in   allows the one-hot grant to be asserted
//   gnt      out  one-hot grant, all zero when en=0 or nothing requests
//   gnt_idx  out  index of the winning channel (holds ptr when nothing requests)
//   any      out  at least one channel requests (independent of en)
module rr_arb4
  import mux4_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  sel_t           ptr,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output sel_t           gnt_idx,
  output logic           any
);

  sel_t cand;

  // Walk the channels in rotating order starting after ptr; the first
  // requester found wins. The 2-bit candidate wraps naturally, so the
  // fourth step lands back on ptr itself.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    any     = 1'b0;
    cand    = ptr;
    for (int k = 1; k <= NCH; k++) begin
      cand = ptr + sel_t'(k);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = any & en;
  end

endmodule

// File: rtl/rr_mux4_tx.sv
// Transmit end of the 4-channel select link. Merges four valid/ready input
// streams onto one registered output word plus a select code {s1,s0}, using
// fair round-robin arbitration at one word per clock.
// Optional feature macro: MUX4_CNT_EN builds per-channel saturating
// accepted-word counters on grant_cnt; without it grant_cnt is tied to 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    per-channel word available
//   in_data     channel i word at [i*W +: W]
//   in_ready    per-channel word consumed this cycle (combinational)
//   out_valid   registered output word valid
//   out_data    registered output word
//   s0, s1      select code of the channel that produced out_data
//   out_ready   downstream accepts out_data this cycle
//   grant_cnt   per-channel accepted-word counters, channel i at [i*CNT_W +: CNT_W]
module rr_mux4_tx
  import mux4_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*W-1:0]   in_data,
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic               s0,
  output logic               s1,
  input  logic               out_ready,
  output logic [NCH*CNT_W-1:0] grant_cnt
);

  state_t         state;
  state_t         state_next;
  logic           load;
  logic           any;
  logic [NCH-1:0] gnt;
  sel_t           gnt_idx;
  sel_t           ptr;
  sel_t           sel_q;
  logic [W-1:0]   data_q;

  assign out_valid = (state == FULL);

  // The output register can take a new word when it is empty or its
  // current word is leaving this cycle, which gives back-to-back transfers.
  assign load = ~out_valid | out_ready;

  // Grants are suppressed while rst is high: the register is being cleared
  // on that edge, so nothing may be reported as consumed.
  rr_arb4 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (load & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign in_ready = gnt;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Occupancy next state: the register fills whenever a load finds a
  // requester and empties when a load finds none; a stall holds it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any) state_next = FULL;
      FULL: if (out_ready && !any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output word, select code and round-robin pointer. They only move when
  // a word is actually loaded; an empty load or a stall leaves them alone.
  // The pointer resets to channel 4 so the first search begins at channel 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= SEL_CH1;
      ptr    <= SEL_CH4;
    end else if (load && any) begin
      data_q <= in_data[gnt_idx*W +: W];
      sel_q  <= gnt_idx;
      ptr    <= gnt_idx;
    end
  end

  assign out_data = data_q;
  assign s0       = sel_q[0];
  assign s1       = sel_q[1];

`ifdef MUX4_CNT_EN
  logic [NCH-1:0][CNT_W-1:0] cnt;

  // Accepted-word counters, one per channel, stopping at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i] && in_ready[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = cnt;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_mux4_tx.sv
// Self-checking bench for rr_mux4_tx: directed scenarios plus a randomized
// run compared against a transaction-level model of the link.
module tb_rr_mux4_tx;

  localparam int W     = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic           clk;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           s0;
  logic           s1;
  logic           out_ready;
  logic [4*CNT_W-1:0] grant_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the output register should hold, which
  // channel was served last, and how many words each channel has sent.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;
  int         m_last;
  int         m_cnt[4];

  rr_mux4_tx #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .s0        (s0),
    .s1        (s1),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First channel after the last served one that has a word, or -1.
  function automatic int model_grant(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    logic [3:0] r;
    r = 4'b0;
    g = model_grant(in_valid, m_last);
    if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] c;
    c = '0;
`ifdef MUX4_CNT_EN
    for (int i = 0; i < 4; i++) c[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
    return c;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic [4*W-1:0] d, input logic ordy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance one clock and move the model by the same edge.
  task automatic tick();
    int g;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = 3;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (!m_valid || out_ready) begin
      g = model_grant(in_valid, m_last);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        m_last  = g;
        if (m_cnt[g] < CMAX) m_cnt[g]++;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 4'hF, 32'h44332211, 1'b1);
    tick();
    tick();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
    if ({s1, s0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_sel got %b want 00", {s1, s0}); end
    if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0000", in_ready); end
    if (grant_cnt !== '0) begin errors++; $display("[TB] FAIL reset_grant_cnt got %h want 0", grant_cnt); end
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || {s1, s0} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_first_word got v=%0b d=%h s=%b want v=1 d=11 s=00", out_valid, out_data, {s1, s0});
    end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 4'b0000, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0100, 32'h00A50000, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_in_ready got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || {s1, s0} !== 2'b10) begin
      errors++; $display("[TB] FAIL single_word got v=%0b d=%h s=%b want v=1 d=a5 s=10", out_valid, out_data, {s1, s0});
    end
    applyStimulus(1'b0, 4'b0000, 32'h00A50000, 1'b1);
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_drop got %b want 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_drain got v=%0b d=%h want v=0 d=a5", out_valid, out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b1, 4'h0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i % 4] || {s1, s0} !== 2'(i % 4)) begin
        errors++;
        $display("[TB] FAIL rr_word%0d got v=%0b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, out_valid, out_data, {s1, s0}, exp_d[i % 4], i % 4);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] exp_d[3] = '{8'h33, 8'h44, 8'h11};
    applyStimulus(1'b1, 4'h0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL stall_in_ready%0d got %b want 0000", i, in_ready); end
      tick();
      if (out_valid !== 1'b1 || out_data !== 8'h22) begin
        errors++; $display("[TB] FAIL stall_hold%0d got v=%0b d=%h want v=1 d=22", i, out_valid, out_data);
      end
    end
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL stall_resume_ready got %b want 0100", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("[TB] FAIL stall_resume%0d got d=%h want %h", i, out_data, exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 4'h0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      errors++; $display("[TB] FAIL midrst_setup got v=%0b d=%h want v=1 d=33", out_valid, out_data);
    end
    applyStimulus(1'b1, 4'hF, 32'h44332211, 1'b0);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b0);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dropped got v=%0b want 0", out_valid); end
    if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_first_grant got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_data !== 8'h11 || {s1, s0} !== 2'b00) begin
      errors++; $display("[TB] FAIL midrst_first_word got d=%h s=%b want d=11 s=00", out_data, {s1, s0});
    end
  endtask

  task automatic test_counter();
    logic [4*CNT_W-1:0] want;
`ifdef MUX4_CNT_EN
    want = 8'b11_00_00_00;
`else
    want = '0;
`endif
    applyStimulus(1'b1, 4'h0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b1000, 32'h5C000000, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 4'b0000, 32'h5C000000, 1'b1);
    tick();
    checks++;
    if (grant_cnt !== want) begin errors++; $display("[TB] FAIL counter_ch4 got %h want %h", grant_cnt, want); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom),
                    {$urandom}, ($urandom_range(0, 3) != 0));
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("[TB] FAIL rand_in_ready cyc %0d got %b want %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || {s1, s0} !== 2'(m_sel) || grant_cnt !== model_cnt()) begin
        errors++;
        $display("[TB] FAIL rand_out cyc %0d got v=%0b d=%h s=%0d c=%h want v=%0b d=%h s=%0d c=%h",
                 c, out_valid, out_data, {s1, s0}, grant_cnt, m_valid, m_data, m_sel, model_cnt());
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_mid_stall();
    test_counter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
